// File: rtl/alu_control_sequencer.sv
// Multi-cycle control sequencer: accepts one instruction per handshake,
// steps it through PC increment, execute and optional branch-target cycles,
// and drives the ALU function code and operand selects for each step.
module alu_control_sequencer #(
  parameter int WORD_SIZE  = 16,
  parameter int FUNC_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [WORD_SIZE-1:0]  instr,
  input  logic                  alu_cond,
  output logic [FUNC_WIDTH-1:0] alu_func_code,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            state,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  // State encodings are visible on the state port, so they are fixed values.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PCINC = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_BRTGT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Opcodes.
  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_ALU = 4'd15;

  // R-type function fields that are jumps through a register.
  localparam logic [5:0] INST_FUNC_JPR = 6'd25;
  localparam logic [5:0] INST_FUNC_JRL = 6'd26;

  // ALU function codes (4-bit native form).
  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;
  localparam logic [3:0] FUNC_ORR = 4'd3;
  localparam logic [3:0] FUNC_IP1 = 4'd8;
  localparam logic [3:0] FUNC_IP2 = 4'd9;
  localparam logic [3:0] FUNC_BNE = 4'd10;
  localparam logic [3:0] FUNC_BGZ = 4'd11;
  localparam logic [3:0] FUNC_BLZ = 4'd12;

  // "No operation" code: all-ones at whatever width the ALU port has.
  localparam logic [FUNC_WIDTH-1:0] FUNC_NONE = '1;

  // Zero-extend (or truncate) a 4-bit macro code to the ALU port width.
  function automatic logic [FUNC_WIDTH-1:0] fext4(input logic [3:0] c);
    logic [FUNC_WIDTH+3:0] t;
    t = {{FUNC_WIDTH{1'b0}}, c};
    return t[FUNC_WIDTH-1:0];
  endfunction

  // Low FUNC_WIDTH bits of the 6-bit instruction func field, zero-extended.
  function automatic logic [FUNC_WIDTH-1:0] fext6(input logic [5:0] c);
    logic [FUNC_WIDTH+5:0] t;
    t = {{FUNC_WIDTH{1'b0}}, c};
    return t[FUNC_WIDTH-1:0];
  endfunction

  logic [2:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] instr_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic [3:0]            op;
  logic [5:0]            fld;
  logic [FUNC_WIDTH-1:0] dec_func;
  logic                  dec_imm;
  logic                  dec_branch;
  logic                  unused_instr_bits;

  assign op  = instr_q[15:12];
  assign fld = instr_q[5:0];
  assign unused_instr_bits = ^instr_q;

  // State register, instruction latch and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && instr_valid) instr_q <= instr;
      if (state_q == S_DONE) count_q <= count_q + 1'b1;
    end
  end

  // Decode of the latched instruction into EXEC-cycle controls.
  always_comb begin
    dec_func   = FUNC_NONE;
    dec_imm    = 1'b0;
    dec_branch = 1'b0;
    unique case (op)
      OP_ALU: begin
        if (fld == INST_FUNC_JPR || fld == INST_FUNC_JRL) dec_func = fext4(FUNC_IP1);
        else dec_func = fext6(fld);
      end
      OP_ADI, OP_LWD, OP_SWD: begin
        dec_func = fext4(FUNC_ADD);
        dec_imm  = 1'b1;
      end
      OP_ORI: begin
        dec_func = fext4(FUNC_ORR);
        dec_imm  = 1'b1;
      end
      OP_LHI: begin
        dec_func = fext4(FUNC_IP2);
        dec_imm  = 1'b1;
      end
      OP_BNE: begin
        dec_func   = fext4(FUNC_BNE);
        dec_branch = 1'b1;
      end
      OP_BEQ: begin
        dec_func   = fext4(FUNC_SUB);
        dec_branch = 1'b1;
      end
      OP_BGZ: begin
        dec_func   = fext4(FUNC_BGZ);
        dec_branch = 1'b1;
      end
      OP_BLZ: begin
        dec_func   = fext4(FUNC_BLZ);
        dec_branch = 1'b1;
      end
      default: dec_func = FUNC_NONE;
    endcase
  end

  // Next-state selection; unknown encodings fall back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = instr_valid ? S_PCINC : S_IDLE;
      S_PCINC: state_d = (dec_func == FUNC_NONE) ? S_DONE : S_EXEC;
      S_EXEC:  state_d = (dec_branch && alu_cond) ? S_BRTGT : S_DONE;
      S_BRTGT: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state and latched instruction only.
  always_comb begin
    alu_func_code = FUNC_NONE;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    case (state_q)
      S_PCINC: begin
        alu_func_code = fext4(FUNC_ADD);
        alu_src_a     = 1'b1;
        alu_src_b     = 2'd2;
      end
      S_EXEC: begin
        alu_func_code = dec_func;
        alu_src_b     = dec_imm ? 2'd1 : 2'd0;
      end
      S_BRTGT: begin
        alu_func_code = fext4(FUNC_ADD);
        alu_src_a     = 1'b1;
        alu_src_b     = 2'd1;
      end
      default: ;
    endcase
  end

  assign instr_ready   = (state_q == S_IDLE);
  assign done          = (state_q == S_DONE);
  assign state         = state_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: directed cases then random instructions,
// checked cycle by cycle against a trace model built from the opcode table.
// A second instance with a 6-bit function port and 4-bit counter shares the
// stimulus to cover width extension and counter wrap.
module tb_alu_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        alu_cond;

  logic        ready_a, srca_a, done_a;
  logic [3:0]  func_a;
  logic [1:0]  srcb_a;
  logic [2:0]  state_a;
  logic [15:0] count_a;

  logic        ready_b, srca_b, done_b;
  logic [5:0]  func_b;
  logic [1:0]  srcb_b;
  logic [2:0]  state_b;
  logic [3:0]  count_b;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_control_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(ready_a),
    .instr(instr), .alu_cond(alu_cond), .alu_func_code(func_a),
    .alu_src_a(srca_a), .alu_src_b(srcb_a), .state(state_a), .done(done_a),
    .retired_count(count_a)
  );

  alu_control_sequencer #(.WORD_SIZE(16), .FUNC_WIDTH(6), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(ready_b),
    .instr(instr), .alu_cond(alu_cond), .alu_func_code(func_b),
    .alu_src_a(srca_b), .alu_src_b(srcb_b), .state(state_b), .done(done_b),
    .retired_count(count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: EXEC-cycle function code for a given port width; bit 6 says whether
  // EXEC is entered at all (decoded code is not all-ones).
  function automatic logic [6:0] model_exec(input logic [15:0] ins, input int w);
    logic [5:0] ones;
    logic [5:0] r;
    logic [5:0] f;
    ones = (w == 4) ? 6'h0F : 6'h3F;
    f = ins[5:0];
    case (ins[15:12])
      4'd15:         r = (f == 6'd25 || f == 6'd26) ? 6'd8 : (f & ones);
      4'd0:          r = 6'd10;
      4'd1:          r = 6'd1;
      4'd2:          r = 6'd11;
      4'd3:          r = 6'd12;
      4'd4, 4'd7, 4'd8: r = 6'd0;
      4'd5:          r = 6'd3;
      4'd6:          r = 6'd9;
      default:       r = ones;
    endcase
    return {(r != ones), r};
  endfunction

  function automatic bit is_branch(input logic [3:0] op);
    return op <= 4'd3;
  endfunction

  function automatic bit is_imm(input logic [3:0] op);
    return op >= 4'd4 && op <= 4'd8;
  endfunction

  // Check all outputs of both instances for one cycle in the given state.
  task automatic check_cycle(input string nm, input int st, input logic [15:0] ins);
    logic [6:0] m4, m6;
    logic [3:0] ef4;
    logic [5:0] ef6;
    logic       ea;
    logic [1:0] eb;
    m4 = model_exec(ins, 4);
    m6 = model_exec(ins, 6);
    ef4 = 4'hF; ef6 = 6'h3F; ea = 1'b0; eb = 2'd0;
    if (st == 1) begin ef4 = 4'd0; ef6 = 6'd0; ea = 1'b1; eb = 2'd2; end
    if (st == 2) begin ef4 = m4[3:0]; ef6 = m6[5:0]; eb = is_imm(ins[15:12]) ? 2'd1 : 2'd0; end
    if (st == 3) begin ef4 = 4'd0; ef6 = 6'd0; ea = 1'b1; eb = 2'd1; end
    chk({nm, ".state"}, state_a, st);
    chk({nm, ".ready"}, ready_a, st == 0);
    chk({nm, ".done"}, done_a, st == 4);
    chk({nm, ".func"}, func_a, ef4);
    chk({nm, ".src_a"}, srca_a, ea);
    chk({nm, ".src_b"}, srcb_a, eb);
    chk({nm, ".w.state"}, state_b, st);
    chk({nm, ".w.func"}, func_b, ef6);
  endtask

  // Issue one instruction from IDLE (entered at #1 after an edge) and follow it
  // to retirement. cond is the ALU condition presented in EXEC; hold keeps
  // instr_valid asserted (with junk on instr) throughout.
  task automatic run(input string nm, input logic [15:0] ins, input bit cond, input bit hold);
    int tr[$];
    logic [6:0] m4;
    m4 = model_exec(ins, 4);
    tr.push_back(1);
    if (m4[6]) tr.push_back(2);
    if (m4[6] && is_branch(ins[15:12]) && cond) tr.push_back(3);
    tr.push_back(4);
    instr = ins;
    instr_valid = 1'b1;
    alu_cond = 1'($urandom);
    @(negedge clk);
    check_cycle({nm, ".idle"}, 0, ins);
    chk({nm, ".count"}, count_a, exp_cnt[15:0]);
    chk({nm, ".w.count"}, count_b, exp_cnt[3:0]);
    @(posedge clk); #1;
    if (!hold) instr_valid = 1'b0;
    instr = 16'($urandom);
    foreach (tr[i]) begin
      alu_cond = (tr[i] == 2) ? cond : 1'($urandom);
      @(negedge clk);
      check_cycle($sformatf("%s.c%0d", nm, i + 1), tr[i], ins);
      @(posedge clk); #1;
    end
    exp_cnt++;
  endtask

  initial begin
    logic [15:0] ins;
    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0; alu_cond = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_cycle("reset", 0, 16'h0);
    chk("reset.count", count_a, 0);
    chk("reset.w.count", count_b, 0);
    @(posedge clk); #1;

    // Reset while in EXEC with a coincident instr_valid aborts the instruction.
    instr = 16'h4123; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort.in_exec", state_a, 2);
    reset = 1'b1; instr_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    chk("abort.state", state_a, 0);
    chk("abort.done", done_a, 0);
    chk("abort.ready", ready_a, 1);
    chk("abort.count", count_a, 0);
    @(negedge clk);
    chk("abort.no_done", done_a, 0);
    chk("abort.stay_idle", state_a, 0);
    @(posedge clk); #1;

    // Directed cases.
    run("adi", 16'h4A05, 1'b1, 1'b0);
    run("beq_t", 16'h1234, 1'b1, 1'b0);
    run("beq_n", 16'h1234, 1'b0, 1'b0);
    run("bgz_t", 16'h2000, 1'b1, 1'b0);
    run("jpr", 16'hF019, 1'b1, 1'b0);
    run("jrl", 16'hF01A, 1'b0, 1'b0);
    run("alu2", 16'hF002, 1'b1, 1'b0);
    run("alu_none", 16'hF03F, 1'b1, 1'b0);
    run("jmp", 16'h9ABC, 1'b1, 1'b0);
    run("lhi", 16'h6FFF, 1'b1, 1'b0);
    run("ori", 16'h5001, 1'b0, 1'b0);
    run("hold1", 16'h7010, 1'b1, 1'b1);
    run("hold2", 16'h0000, 1'b1, 1'b1);
    run("hold3", 16'hA000, 1'b0, 1'b1);
    instr_valid = 1'b0;

    // Random instructions, enough retirements to wrap the narrow counter.
    for (int k = 0; k < 40; k++) begin
      ins = 16'($urandom);
      if (ins[15:12] == 4'd15 && ins[3:0] == 4'hF) ins[5:0] = 6'h3F;
      run($sformatf("rnd%0d", k), ins, 1'($urandom), 1'($urandom));
      instr_valid = 1'b0;
    end

    @(negedge clk);
    chk("final.count", count_a, exp_cnt[15:0]);
    chk("final.w.count", count_b, exp_cnt[3:0]);
    chk("final.state", state_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
